// File: rtl/day08_pkg.sv
// Shared types and defaults for the day-08 batch-distance interface.
// Holds the coordinate/point typedefs, the batch and coordinate defaults
// shared with the consumer top, and the feeder FSM state encoding.
package day08_pkg;

  localparam int unsigned DEFAULT_MAX_NODE_COUNT  = 2000;
  localparam int unsigned DEFAULT_COORD_BIT_WIDTH = 12;
  localparam int unsigned DEFAULT_DIMENSIONS      = 3;
  localparam int unsigned DEFAULT_BATCH_SIZE      = 16;

  typedef logic [DEFAULT_COORD_BIT_WIDTH-1:0] coord_t;
  typedef coord_t point_t [DEFAULT_DIMENSIONS];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/point_store.sv
// Point storage for the batch feeder.
// Ports:
//   clk            - clock
//   wr_en/wr_addr  - sequential write of wr_coord into slot wr_addr
//   count          - number of valid points (bounds the read window)
//   rd_base        - first point index of the read window
//   rd_*_c         - combinational BATCH_SIZE-wide window; slots at or past
//                    count read as zero with valid cleared
module point_store #(
  parameter int unsigned  MAX_NODE_COUNT  = 2000,
  parameter int unsigned  COORD_BIT_WIDTH = 12,
  parameter int unsigned  DIMENSIONS      = 3,
  parameter int unsigned  BATCH_SIZE      = 16,
  localparam int unsigned INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT),
  localparam int unsigned ADDR_BIT_WIDTH  = INDEX_BIT_WIDTH + 2
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [INDEX_BIT_WIDTH-1:0] wr_addr,
  input  logic [COORD_BIT_WIDTH-1:0] wr_coord [0:DIMENSIONS-1],
  input  logic [INDEX_BIT_WIDTH:0]   count,
  input  logic [ADDR_BIT_WIDTH-1:0]  rd_base,
  output logic [COORD_BIT_WIDTH-1:0] rd_coords_c  [0:BATCH_SIZE-1][0:DIMENSIONS-1],
  output logic [INDEX_BIT_WIDTH-1:0] rd_indices_c [0:BATCH_SIZE-1],
  output logic [BATCH_SIZE-1:0]      rd_valid_c
);

  logic [COORD_BIT_WIDTH-1:0] r_mem [0:MAX_NODE_COUNT-1][0:DIMENSIONS-1];
  logic [ADDR_BIT_WIDTH-1:0]  w_addr [0:BATCH_SIZE-1];

  // Write port; storage is intentionally not reset, only the count is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int d = 0; d < int'(DIMENSIONS); d++) begin
        r_mem[wr_addr][d] <= wr_coord[d];
      end
    end
  end

  // Read window; the valid test also keeps the memory index in range.
  always_comb begin
    for (int k = 0; k < int'(BATCH_SIZE); k++) begin
      w_addr[k]       = rd_base + ADDR_BIT_WIDTH'(k);
      rd_valid_c[k]   = w_addr[k] < ADDR_BIT_WIDTH'(count);
      rd_indices_c[k] = '0;
      for (int d = 0; d < int'(DIMENSIONS); d++) begin
        rd_coords_c[k][d] = '0;
      end
      if (rd_valid_c[k]) begin
        rd_indices_c[k] = w_addr[k][INDEX_BIT_WIDTH-1:0];
        for (int d = 0; d < int'(DIMENSIONS); d++) begin
          rd_coords_c[k][d] = r_mem[w_addr[k][INDEX_BIT_WIDTH-1:0]][d];
        end
      end
    end
  end

endmodule

// File: rtl/pair_batch_feeder.sv
// Transmit side of the day-08 batch-distance interface.
// Stores loaded 3-D points and replays them as fixed-width batches, one line
// per reference point i carrying points i..N-1, under consumer backpressure.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   load_valid/load_coord    - point append request (accepted when load_ready)
//   load_ready, node_count   - append readiness and stored point count
//   start, busy, done        - stream request, running flag, completion pulse
//   batch_*                  - registered batch payload and flags
//   in_ready                 - consumer accept; fire = |batch_valid && in_ready
module pair_batch_feeder
#(
  parameter int unsigned  MAX_NODE_COUNT  = day08_pkg::DEFAULT_MAX_NODE_COUNT,
  parameter int unsigned  COORD_BIT_WIDTH = day08_pkg::DEFAULT_COORD_BIT_WIDTH,
  parameter int unsigned  DIMENSIONS      = day08_pkg::DEFAULT_DIMENSIONS,
  parameter int unsigned  BATCH_SIZE      = day08_pkg::DEFAULT_BATCH_SIZE,
  localparam int unsigned INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  input  logic [COORD_BIT_WIDTH-1:0] load_coord [0:DIMENSIONS-1],
  output logic                       load_ready,
  output logic [INDEX_BIT_WIDTH:0]   node_count,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [COORD_BIT_WIDTH-1:0] batch_coords  [0:BATCH_SIZE-1][0:DIMENSIONS-1],
  output logic [INDEX_BIT_WIDTH-1:0] batch_indices [0:BATCH_SIZE-1],
  output logic [BATCH_SIZE-1:0]      batch_valid,
  output logic                       batch_line_end,
  output logic                       batch_stream_end,
  input  logic                       in_ready
);
  import day08_pkg::*;

  localparam int unsigned CNT_W = INDEX_BIT_WIDTH + 1;
  localparam int unsigned AW    = INDEX_BIT_WIDTH + 2;

  feeder_state_t              r_state;
  logic [CNT_W-1:0]           r_count;
  logic [AW-1:0]              r_line;
  logic [AW-1:0]              r_cursor;
  logic                       r_load_ready;
  logic                       r_busy;
  logic                       r_done;
  logic [COORD_BIT_WIDTH-1:0] r_coords  [0:BATCH_SIZE-1][0:DIMENSIONS-1];
  logic [INDEX_BIT_WIDTH-1:0] r_indices [0:BATCH_SIZE-1];
  logic [BATCH_SIZE-1:0]      r_valid;
  logic                       r_line_end;
  logic                       r_stream_end;

  logic                       w_load;
  logic                       w_fire;
  logic [CNT_W-1:0]           w_count_next;
  logic                       w_ready_next;
  logic [AW-1:0]              w_next_line;
  logic [AW-1:0]              w_next_cursor;
  logic                       w_next_line_end;
  logic                       w_next_stream_end;
  logic [COORD_BIT_WIDTH-1:0] w_rd_coords  [0:BATCH_SIZE-1][0:DIMENSIONS-1];
  logic [INDEX_BIT_WIDTH-1:0] w_rd_indices [0:BATCH_SIZE-1];
  logic [BATCH_SIZE-1:0]      w_rd_valid;

  assign w_load = load_valid && r_load_ready;
  assign w_fire = (r_state == ST_RUN) && (|r_valid) && in_ready;

  // Append port: store depth and load readiness for the following cycle.
  always_comb begin
    w_count_next = r_count + CNT_W'(w_load);
    w_ready_next = (((r_state == ST_IDLE) && !start) || (r_state == ST_FIN)) &&
                   (w_count_next < CNT_W'(MAX_NODE_COUNT));
  end

  // Position and flags of the batch to present next (from IDLE: line 0, cursor 0).
  always_comb begin
    w_next_line   = r_line;
    w_next_cursor = r_cursor;
    if (r_state == ST_IDLE) begin
      w_next_line   = '0;
      w_next_cursor = '0;
    end else if (r_line_end) begin
      // New reference point r_line+1 lands in slot 0.
      w_next_line   = r_line + AW'(1);
      w_next_cursor = r_line + AW'(1);
    end else begin
      w_next_cursor = r_cursor + AW'(BATCH_SIZE);
    end
    w_next_line_end   = (w_next_cursor + AW'(BATCH_SIZE)) >= AW'(r_count);
    w_next_stream_end = w_next_line_end && (w_next_line == (AW'(r_count) - AW'(2)));
  end

  point_store #(
    .MAX_NODE_COUNT  (MAX_NODE_COUNT),
    .COORD_BIT_WIDTH (COORD_BIT_WIDTH),
    .DIMENSIONS      (DIMENSIONS),
    .BATCH_SIZE      (BATCH_SIZE)
  ) u_store (
    .clk          (clk),
    .wr_en        (w_load),
    .wr_addr      (r_count[INDEX_BIT_WIDTH-1:0]),
    .wr_coord     (load_coord),
    .count        (r_count),
    .rd_base      (w_next_cursor),
    .rd_coords_c  (w_rd_coords),
    .rd_indices_c (w_rd_indices),
    .rd_valid_c   (w_rd_valid)
  );

  // FSM, counters and registered batch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_line       <= '0;
      r_cursor     <= '0;
      r_load_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_valid      <= '0;
      r_line_end   <= 1'b0;
      r_stream_end <= 1'b0;
      for (int k = 0; k < int'(BATCH_SIZE); k++) begin
        r_indices[k] <= '0;
        for (int d = 0; d < int'(DIMENSIONS); d++) begin
          r_coords[k][d] <= '0;
        end
      end
    end else begin
      r_done       <= 1'b0;
      r_count      <= w_count_next;
      r_load_ready <= w_ready_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (r_count >= CNT_W'(2)) begin
              r_state      <= ST_RUN;
              r_busy       <= 1'b1;
              r_line       <= w_next_line;
              r_cursor     <= w_next_cursor;
              r_coords     <= w_rd_coords;
              r_indices    <= w_rd_indices;
              r_valid      <= w_rd_valid;
              r_line_end   <= w_next_line_end;
              r_stream_end <= w_next_stream_end;
            end else begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_fire) begin
            if (r_stream_end) begin
              r_state      <= ST_FIN;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_valid      <= '0;
              r_line_end   <= 1'b0;
              r_stream_end <= 1'b0;
              for (int k = 0; k < int'(BATCH_SIZE); k++) begin
                r_indices[k] <= '0;
                for (int d = 0; d < int'(DIMENSIONS); d++) begin
                  r_coords[k][d] <= '0;
                end
              end
            end else begin
              r_line       <= w_next_line;
              r_cursor     <= w_next_cursor;
              r_coords     <= w_rd_coords;
              r_indices    <= w_rd_indices;
              r_valid      <= w_rd_valid;
              r_line_end   <= w_next_line_end;
              r_stream_end <= w_next_stream_end;
            end
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign load_ready       = r_load_ready;
  assign node_count       = r_count;
  assign busy             = r_busy;
  assign done             = r_done;
  assign batch_coords     = r_coords;
  assign batch_indices    = r_indices;
  assign batch_valid      = r_valid;
  assign batch_line_end   = r_line_end;
  assign batch_stream_end = r_stream_end;

endmodule

// File: tb/tb_pair_batch_feeder.sv
// Self-checking bench for pair_batch_feeder: random point sets and random
// backpressure checked against a line/cursor reference model.
module tb_pair_batch_feeder;
  import day08_pkg::*;

  localparam int MAXN = 2000;
  localparam int B    = 16;
  localparam int D    = 3;
  localparam int CW   = 12;
  localparam int IW   = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [CW-1:0] load_coord [0:D-1];
  logic          load_ready;
  logic [IW:0]   node_count;
  logic          start;
  logic          busy;
  logic          done;
  logic [CW-1:0] batch_coords  [0:B-1][0:D-1];
  logic [IW-1:0] batch_indices [0:B-1];
  logic [B-1:0]  batch_valid;
  logic          batch_line_end;
  logic          batch_stream_end;
  logic          in_ready;

  pair_batch_feeder #(
    .MAX_NODE_COUNT  (MAXN),
    .COORD_BIT_WIDTH (CW),
    .DIMENSIONS      (D),
    .BATCH_SIZE      (B)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .load_valid       (load_valid),
    .load_coord       (load_coord),
    .load_ready       (load_ready),
    .node_count       (node_count),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .batch_coords     (batch_coords),
    .batch_indices    (batch_indices),
    .batch_valid      (batch_valid),
    .batch_line_end   (batch_line_end),
    .batch_stream_end (batch_stream_end),
    .in_ready         (in_ready)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  coord_t m_pts [0:MAXN-1][0:D-1];
  int     m_n = 0;
  int     exp_i[$];
  int     exp_c[$];
  logic [B-1:0] first_valid;
  int     last_slot0;

  // Reference stream: one line per reference i in 0..N-2, batches at c = i, i+B, ... < N.
  function automatic void build_expected(input int n);
    exp_i.delete();
    exp_c.delete();
    for (int i = 0; i <= n - 2; i++) begin
      for (int c = i; c < n; c += B) begin
        exp_i.push_back(i);
        exp_c.push_back(c);
      end
    end
  endfunction

  task automatic apply_reset();
    rst = 1'b1; load_valid = 1'b0; start = 1'b0; in_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_n = 0;
  endtask

  task automatic load_n(input int n);
    for (int p = 0; p < n; p++) begin
      for (int d = 0; d < D; d++) load_coord[d] = CW'($urandom);
      load_valid = 1'b1;
      @(negedge clk);
      if (m_n < MAXN) begin
        for (int d = 0; d < D; d++) m_pts[m_n][d] = load_coord[d];
        m_n++;
      end
    end
    load_valid = 1'b0;
  endtask

  // Issues start and follows the stream; returns early once batch stop_at is on offer.
  task automatic run_stream(input int mode, input int stop_at, input bit poke_load,
                            output int dut_fires);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    bit bad;
    int bad_k;
    int i, c, j;
    logic [B-1:0] exp_v;
    logic exp_le, exp_se;
    dut_fires = 0;
    build_expected(m_n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx < exp_i.size() && cyc < 4000) begin
      i = exp_i[idx];
      c = exp_c[idx];
      for (int k = 0; k < B; k++) exp_v[k] = (c + k < m_n);
      exp_le = (c + B >= m_n);
      exp_se = exp_le && (i == m_n - 2);
      checks++;
      if (batch_valid !== exp_v || batch_line_end !== exp_le ||
          batch_stream_end !== exp_se || busy !== 1'b1) begin
        errors++;
        $display("FAIL batch_flags #%0d: got valid=%h le=%b se=%b busy=%b, want valid=%h le=%b se=%b busy=1",
                 idx, batch_valid, batch_line_end, batch_stream_end, busy, exp_v, exp_le, exp_se);
      end
      bad = 1'b0;
      bad_k = 0;
      for (int k = 0; k < B; k++) begin
        j = c + k;
        if (j < m_n) begin
          if (batch_indices[k] !== IW'(j)) bad = 1'b1;
          for (int d = 0; d < D; d++) if (batch_coords[k][d] !== m_pts[j][d]) bad = 1'b1;
        end else begin
          if (batch_indices[k] !== '0) bad = 1'b1;
          for (int d = 0; d < D; d++) if (batch_coords[k][d] !== '0) bad = 1'b1;
        end
        if (bad && bad_k == 0) bad_k = k + 1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL batch_slots #%0d: slot %0d got index %0d, want index %0d (line %0d cursor %0d)",
                 idx, bad_k - 1, batch_indices[bad_k-1],
                 (c + bad_k - 1 < m_n) ? c + bad_k - 1 : 0, i, c);
      end
      if (cyc == 0) first_valid = batch_valid;
      last_slot0 = int'(batch_indices[0]);
      if (idx == stop_at) return;
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_ready = rdy;
      load_valid = poke_load && (cyc == 2);
      if (rdy && (|batch_valid)) dut_fires++;
      @(negedge clk);
      load_valid = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    in_ready = 1'b0;
    checks++;
    if (idx != exp_i.size()) begin
      errors++;
      $display("FAIL stream_timeout: reached batch %0d, want %0d", idx, exp_i.size());
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || batch_valid !== '0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b valid=%h, want done=1 busy=0 valid=0",
               done, busy, batch_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_clear: got done=%b load_ready=%b, want done=0 load_ready=1",
               done, load_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b0; start = 1'b0; in_ready = 1'b0;
    for (int d = 0; d < D; d++) load_coord[d] = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (batch_valid !== '0 || busy !== 1'b0 || done !== 1'b0 || node_count !== '0 ||
        load_ready !== 1'b0 || batch_line_end !== 1'b0 || batch_stream_end !== 1'b0 ||
        batch_indices[0] !== '0 || batch_coords[0][0] !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%h busy=%b done=%b count=%0d ready=%b, want all 0",
               batch_valid, busy, done, node_count, load_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got load_ready=%b, want 1", load_ready);
    end
    m_n = 0;
  endtask

  task automatic test_n3();
    int f;
    apply_reset();
    load_n(3);
    run_stream(0, -1, 1'b0, f);
    checks++;
    if (f != 2 || first_valid !== 16'h0007) begin
      errors++;
      $display("FAIL n3_stream: got fires=%0d first_valid=%h, want 2 and 0007", f, first_valid);
    end
  endtask

  task automatic test_n20();
    int f;
    apply_reset();
    load_n(20);
    run_stream(0, -1, 1'b0, f);
    checks++;
    if (f != exp_i.size() || first_valid !== 16'hFFFF || last_slot0 != 18) begin
      errors++;
      $display("FAIL n20_stream: got fires=%0d first_valid=%h last_slot0=%0d, want %0d FFFF 18",
               f, first_valid, last_slot0, exp_i.size());
    end
  endtask

  // Replays the retained N=20 store under random stalls with a load poked mid-run.
  task automatic test_backpressure();
    int f;
    run_stream(1, -1, 1'b1, f);
    checks++;
    if (f != exp_i.size() || node_count !== 12'(m_n)) begin
      errors++;
      $display("FAIL backpressure: got fires=%0d count=%0d, want %0d and %0d",
               f, node_count, exp_i.size(), m_n);
    end
  endtask

  task automatic test_tiny();
    for (int n = 0; n < 2; n++) begin
      apply_reset();
      load_n(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || batch_valid !== '0) begin
        errors++;
        $display("FAIL tiny_done n=%0d: got done=%b busy=%b valid=%h, want 1 0 0",
                 n, done, busy, batch_valid);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || batch_valid !== '0) begin
        errors++;
        $display("FAIL tiny_after n=%0d: got done=%b busy=%b valid=%h, want 0 0 0",
                 n, done, busy, batch_valid);
      end
    end
  endtask

  task automatic test_full();
    apply_reset();
    load_n(MAXN);
    checks++;
    if (node_count !== 12'(MAXN) || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_store: got count=%0d ready=%b, want 2000 0", node_count, load_ready);
    end
    load_n(1);
    checks++;
    if (node_count !== 12'(MAXN)) begin
      errors++;
      $display("FAIL full_drop: got count=%0d, want 2000", node_count);
    end
  endtask

  task automatic test_reset_mid();
    int f;
    apply_reset();
    load_n(20);
    run_stream(0, 4, 1'b0, f);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (batch_valid !== '0 || node_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%h count=%0d busy=%b, want 0 0 0",
               batch_valid, node_count, busy);
    end
    rst = 1'b0;
    in_ready = 1'b0;
    @(negedge clk);
    m_n = 0;
    load_n(3);
    run_stream(0, -1, 1'b0, f);
    checks++;
    if (f != 2 || first_valid !== 16'h0007) begin
      errors++;
      $display("FAIL reset_reload: got fires=%0d first_valid=%h, want 2 and 0007", f, first_valid);
    end
  endtask

  initial begin
    test_reset();
    test_n3();
    test_n20();
    test_backpressure();
    test_tiny();
    test_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
